// File: rtl/main_mem_ctrl_pkg.sv
// Shared state encoding, block geometry and address helpers for the main-memory controller.
package main_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, WRITE} stateT;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_W        = 3;
    localparam int BUS_COUNT_W     = 4;

    // AND with a word index to clear the offset bits and get its block base.
    function automatic logic [31:0] blockBaseMask();
        return ~32'(WORDS_PER_BLOCK - 1);
    endfunction

endpackage

// File: rtl/main_mem_ctrl_burst_seq.sv
// Burst sequencer: counts out the read latency, then produces the eight beat indices of a fill.
// MAIN_MEM_CRITICAL_WORD_FIRST_EN starts the burst at the requested word instead of word 0.
module burst_seq
    import main_mem_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OFFSET_W-1:0] startOffset,
    input  logic                inWait,
    input  logic                inBurst,
    output logic                beatFire,
    output logic [OFFSET_W-1:0] beatIdx,
    output logic                beatLast,
    output logic                burstDone
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    logic [LAT_W-1:0]       latCnt;
    logic [BUS_COUNT_W-1:0] beatCnt;

    // The first beat leaves from WAIT once the latency count is spent; the rest leave from BURST.
    assign beatFire  = (inWait && latCnt == '0) || (inBurst && !beatCnt[BUS_COUNT_W-1]);
    assign beatLast  = (beatCnt[OFFSET_W-1:0] == OFFSET_W'(WORDS_PER_BLOCK - 1));
    assign burstDone = inBurst && beatCnt[BUS_COUNT_W-1];

`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    logic [OFFSET_W-1:0] firstIdx;

    // 3-bit sum keeps the beat inside the requested block.
    assign beatIdx = firstIdx + beatCnt[OFFSET_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            firstIdx <= '0;
        end else if (start) begin
            firstIdx <= startOffset;
        end
    end
`else
    logic unusedOffset;

    assign unusedOffset = ^startOffset;
    assign beatIdx      = beatCnt[OFFSET_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latCnt  <= '0;
            beatCnt <= '0;
        end else if (start) begin
            latCnt  <= LAT_W'(READ_LATENCY - 1);
            beatCnt <= '0;
        end else begin
            if (inWait && latCnt != '0) begin
                latCnt <= latCnt - LAT_W'(1);
            end
            if (beatFire) begin
                beatCnt <= beatCnt + BUS_COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller behind L1: single-word stores and serial 8-word block fills from a word array.
// MAIN_MEM_CRITICAL_WORD_FIRST_EN (in burst_seq) makes fills start at the requested word.
module main_mem_ctrl
    import main_mem_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_DEPTH       = 1024,
    parameter int READ_LATENCY    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   ready,
    output logic                   addr_ack,
    output logic [DATA_W-1:0]      bus_data,
    output logic [BUS_COUNT_W-1:0] bus_count,
    output logic                   bus_valid,
    output logic                   bus_last,
    output logic                   store_done
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [IDX_W-1:0] BASE_MASK = IDX_W'(blockBaseMask());

    stateT               state;
    logic [IDX_W-1:0]    reqIdx;
    logic [IDX_W-1:0]    memIdx;
    logic                accept;
    logic                seqFire;
    logic [OFFSET_W-1:0] seqIdx;
    logic                seqLast;
    logic                seqDone;
    logic                unusedAddrHi;
    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    // Address bits above the array size alias onto the same words.
    assign unusedAddrHi = ^req_addr[ADDR_W-1:IDX_W];
    assign accept       = ready && req_valid;
    assign memIdx       = (reqIdx & BASE_MASK) | IDX_W'(seqIdx);

    burst_seq #(
        .READ_LATENCY(READ_LATENCY)
    ) seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept && !req_write),
        .startOffset(req_addr[OFFSET_W-1:0]),
        .inWait     (state == WAIT),
        .inBurst    (state == BURST),
        .beatFire   (seqFire),
        .beatIdx    (seqIdx),
        .beatLast   (seqLast),
        .burstDone  (seqDone)
    );

    // The array has no reset so a controller reset leaves memory contents intact.
    always_ff @(posedge clk) begin
        if (accept && req_write) begin
            mem[req_addr[IDX_W-1:0]] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready      <= 1'b0;
            addr_ack   <= 1'b0;
            store_done <= 1'b0;
            bus_valid  <= 1'b0;
            bus_data   <= '0;
            bus_count  <= '0;
            bus_last   <= 1'b0;
            reqIdx     <= '0;
        end else begin
            addr_ack   <= 1'b0;
            store_done <= 1'b0;
            bus_valid  <= seqFire;
            bus_data   <= seqFire ? mem[memIdx] : '0;
            bus_count  <= seqFire ? BUS_COUNT_W'(seqIdx) : '0;
            bus_last   <= seqFire && seqLast;

            case (state)
                IDLE: begin
                    if (accept) begin
                        ready    <= 1'b0;
                        addr_ack <= 1'b1;
                        reqIdx   <= req_addr[IDX_W-1:0];
                        if (req_write) begin
                            store_done <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                WAIT: begin
                    if (seqFire) begin
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (seqDone) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: randomized stores and fills against a word-array model.
module tb_main_mem_ctrl;

    localparam int READ_LATENCY = 2;
    localparam int MEM_DEPTH    = 1024;
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        ready;
    logic        addr_ack;
    logic [31:0] bus_data;
    logic [3:0]  bus_count;
    logic        bus_valid;
    logic        bus_last;
    logic        store_done;

    typedef struct {
        bit          isStore;
        int          count;
        logic [31:0] data;
        bit          last;
        bit          first;
    } expT;

    expT         expQ[$];
    logic [31:0] model [MEM_DEPTH];
    int          total = 0;
    int          bad   = 0;

    main_mem_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MEM_DEPTH   (MEM_DEPTH),
        .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ready     (ready),
        .addr_ack  (addr_ack),
        .bus_data  (bus_data),
        .bus_count (bus_count),
        .bus_valid (bus_valid),
        .bus_last  (bus_last),
        .store_done(store_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: event did not occur as required at %0t", name, $time);
    endtask

    // A fill returns the whole aligned block, starting at word 0 or at the requested word.
    task automatic pushRead(input logic [31:0] addr);
        int base;
        int startIdx;
        base     = int'(addr[9:0]) & ~7;
        startIdx = CWF ? int'(addr[2:0]) : 0;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (startIdx + k) % 8;
            expQ.push_back('{isStore: 1'b0, count: idx, data: model[base + idx],
                             last: (k == 7), first: (k == 0)});
        end
    endtask

    // Presents a request and holds it until addr_ack; the caller decides whether to drop it.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        int waited;
        waited    = 0;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_valid = 1'b1;
        if (wr) begin
            model[addr[9:0]] = data;
            expQ.push_back('{isStore: 1'b1, count: 0, data: '0, last: 1'b0, first: 1'b0});
        end else begin
            pushRead(addr);
        end
        do begin
            @(negedge clk);
            waited++;
        end while (!addr_ack && waited < 60);
        if (!addr_ack) failNow("ackTimeout");
    endtask

    task automatic releaseReq();
        req_valid = 1'b0;
        req_addr  = $urandom();
        req_wdata = $urandom();
        req_write = 1'($urandom_range(0, 1));
    endtask

    task automatic waitReady();
        int waited;
        waited = 0;
        while (!ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) failNow("readyTimeout");
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
        checkOutput({tag, "_addrAck"}, 32'(addr_ack), 32'd0);
        checkOutput({tag, "_busValid"}, 32'(bus_valid), 32'd0);
        checkOutput({tag, "_busData"}, bus_data, 32'd0);
        checkOutput({tag, "_busCount"}, 32'(bus_count), 32'd0);
        checkOutput({tag, "_busLast"}, 32'(bus_last), 32'd0);
        checkOutput({tag, "_storeDone"}, 32'(store_done), 32'd0);
    endtask

    // Monitor: pops one expectation per store_done or bus beat and checks handshake timing.
    initial begin : monitor
        int  sinceAck;
        bit  haveAck;
        bit  lastStore;
        bit  prevReady;
        expT e;
        sinceAck  = 0;
        haveAck   = 1'b0;
        lastStore = 1'b0;
        prevReady = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                haveAck   = 1'b0;
                prevReady = 1'b0;
                continue;
            end
            if (addr_ack) begin
                checkOutput("ackOnlyWhenReady", 32'({prevReady, ready}), 32'b10);
                haveAck   = 1'b1;
                sinceAck  = 0;
                lastStore = store_done;
            end else begin
                sinceAck++;
            end
            if (store_done) begin
                checkOutput("storeWithAck", 32'(addr_ack), 32'd1);
                if (expQ.size() == 0) begin
                    failNow("unexpectedStore");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("storeKind", 32'(e.isStore), 32'd1);
                end
            end
            if (bus_valid) begin
                if (expQ.size() == 0) begin
                    failNow("unexpectedBeat");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beatKind", 32'(e.isStore), 32'd0);
                    checkOutput("beatCount", 32'(bus_count), 32'(e.count));
                    checkOutput("beatData", bus_data, e.data);
                    checkOutput("beatLast", 32'(bus_last), 32'(e.last));
                    if (e.first) checkOutput("firstBeatLatency", 32'(sinceAck), 32'(READ_LATENCY));
                end
            end else begin
                checkOutput("idleBusData", bus_data, 32'd0);
                checkOutput("idleBusCountLast", 32'({bus_count, bus_last}), 32'd0);
            end
            if (ready && !prevReady && haveAck) begin
                checkOutput("readyReturn", 32'(sinceAck), lastStore ? 32'd1 : 32'(READ_LATENCY + 8));
            end
            prevReady = ready;
        end
    end

    initial begin : driver
        int beats;
        int waited;
        logic [31:0] addr;

        #1;
        checkAllZero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("readyBeforeEdge", 32'(ready), 32'd0);
        @(negedge clk);
        checkOutput("readyAfterEdge", 32'(ready), 32'd1);

        // Fill the low 128 words so every fill below reads known data.
        for (int i = 0; i < 128; i++) begin
            applyStimulus(1'b1, ($urandom() << 10) | 32'(i), $urandom());
            releaseReq();
            waitReady();
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 32'h40 + 32'(k), 32'hA0 + 32'(k));
            releaseReq();
            waitReady();
        end

        applyStimulus(1'b0, 32'h43, '0);
        releaseReq();
        waitReady();
        applyStimulus(1'b0, 32'h45, '0);
        releaseReq();
        waitReady();

        applyStimulus(1'b1, 32'h12, 32'hDEADBEEF);
        releaseReq();
        waitReady();
        applyStimulus(1'b0, 32'h10, '0);
        releaseReq();
        waitReady();

        applyStimulus(1'b1, 32'h400, 32'h55);
        releaseReq();
        waitReady();
        applyStimulus(1'b0, 32'h000, '0);
        releaseReq();
        waitReady();

        // Held request: the next one waits through WAIT and BURST and is taken on return to idle.
        applyStimulus(1'b0, 32'h43, '0);
        applyStimulus(1'b1, 32'h44, 32'h0BADF00D);
        applyStimulus(1'b0, 32'h47, '0);
        releaseReq();
        waitReady();

        for (int i = 0; i < 40; i++) begin
            addr = ($urandom() << 10) | 32'($urandom_range(0, 127));
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom());
            if ($urandom_range(0, 2) != 0) begin
                releaseReq();
                waitReady();
            end
        end
        releaseReq();
        waitReady();

        // Reset in the middle of a fill, then confirm the array survived.
        applyStimulus(1'b0, 32'h48, '0);
        releaseReq();
        beats  = 0;
        waited = 0;
        while (beats < 4 && waited < 40) begin
            @(negedge clk);
            waited++;
            if (bus_valid) beats++;
        end
        if (beats < 4) failNow("beatTimeout");
        #2 rst_n = 1'b0;
        expQ.delete();
        #1 checkAllZero("midReset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("readyAfterMidReset0", 32'(ready), 32'd0);
        @(negedge clk);
        checkOutput("readyAfterMidReset1", 32'(ready), 32'd1);
        applyStimulus(1'b0, 32'h48, '0);
        releaseReq();
        waitReady();
        applyStimulus(1'b0, 32'h40, '0);
        releaseReq();
        waitReady();

        repeat (4) @(negedge clk);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
